uart_rx_stream: RTL and testbench

- UART receiver sitting between the ICE_27 pad and the PipelineC core input on the Catboard.
- Synchronises the asynchronous serial line and recovers 8N1 frames by mid-bit sampling.
- Presents each received byte on a valid/ready stream with a one-entry holding register.
- Flags framing and overrun errors as single-cycle pulses.

---
 rtl/uart_pkg.sv | 15 +
 rtl/bit_sync.sv | 24 ++
 rtl/uart_rx_stream.sv | 123 ++++++++++++
 tb/tb_uart_rx_stream.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/bit_sync.sv
// N-stage single-bit synchroniser for asynchronous inputs (serial line, buttons).
module bit_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx_stream.sv
// 8N1 UART receiver with mid-bit sampling, feeding a one-entry valid/ready holding register.
// Stream handshake: a byte transfers in every cycle where out_valid and out_ready are both high;
// out_valid never drops without a transfer, and out_ready is ignored while out_valid is low.
module uart_rx_stream
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk_100p0,
  input  logic       rst_n,
  input  logic       rxd_in,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       framing_err,
  output logic       overrun_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 bit_end;
  logic                 deliver;
  logic                 frame_bad;

  bit_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk_100p0),
    .rst_n (rst_n),
    .d     (rxd_in),
    .q     (rx_s)
  );

  assign bit_end   = (cnt == CNT_LAST);
  assign deliver   = (state == STOP) && bit_end && rx_s;
  assign frame_bad = (state == STOP) && bit_end && !rx_s;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk_100p0 or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          // A start bit that is gone by its midpoint is a glitch, not a frame.
          if (cnt == CNT_HALF) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (idx == IDX_LAST) state <= STOP;
            else                 idx   <= idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          // Leaving at the stop-bit midpoint gives half a bit of resync margin.
          if (bit_end) begin
            cnt   <= '0;
            state <= rx_s ? IDLE : BREAK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_100p0 or negedge rst_n) begin
    if (!rst_n) begin
      out_data    <= '0;
      out_valid   <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      framing_err <= frame_bad;
      overrun_err <= deliver && out_valid && !out_ready;
      // A pop and a push in the same cycle replace the held byte without loss.
      if (deliver && (!out_valid || out_ready)) begin
        out_data  <= shreg;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_stream.sv
// Directed bench for uart_rx_stream with CLKS_PER_BIT=16, SYNC_STAGES=2.
module tb_uart_rx_stream;

  localparam int CPB = 16;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_pops;
    int         exp_fe;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       rxd;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       framing_err;
  logic       overrun_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_edge = 0;

  int         pop_cnt = 0;
  logic [7:0] last_pop = 8'h00;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         valid_hi_cnt = 0;
  int         valid_lo_cnt = 0;
  int         busy_cnt = 0;
  int         rise_edge = -1;
  logic       prev_valid = 1'b0;

  vec_t vecs[6];

  uart_rx_stream #(
    .CLKS_PER_BIT (CPB),
    .SYNC_STAGES  (2)
  ) dut (
    .clk_100p0   (clk),
    .rst_n       (rst_n),
    .rxd_in      (rxd),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .framing_err (framing_err),
    .overrun_err (overrun_err),
    .busy        (busy)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: samples 1 ns after the falling edge, inputs are driven exactly on it
  always @(negedge clk) begin
    #1;
    if (out_valid) valid_hi_cnt++;
    else           valid_lo_cnt++;
    if (out_valid && out_ready) begin
      pop_cnt++;
      last_pop = out_data;
    end
    if (framing_err) fe_cnt++;
    if (overrun_err) ov_cnt++;
    if (busy)        busy_cnt++;
    if (out_valid && !prev_valid) rise_edge = cyc;
    prev_valid = out_valid;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // driver: full frame; ready_k >= 0 pulses out_ready on exactly that bit-cycle
  task automatic send_frame(input logic [7:0] d, input logic stop, input int ready_k);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    @(negedge clk);
    start_edge = cyc + 1;
    for (int k = 0; k < 10 * CPB; k++) begin
      rxd = bits[k / CPB];
      if (ready_k >= 0) out_ready = (k == ready_k);
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
    #2;
  endtask

  initial begin
    int p0, f0, o0, v0, l0, b0;

    vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_pops: 1, exp_fe: 0};
    vecs[1] = '{data: 8'h00, stop: 1'b1, exp_pops: 1, exp_fe: 0};
    vecs[2] = '{data: 8'hFF, stop: 1'b1, exp_pops: 1, exp_fe: 0};
    vecs[3] = '{data: 8'h5A, stop: 1'b1, exp_pops: 1, exp_fe: 0};
    vecs[4] = '{data: 8'h55, stop: 1'b0, exp_pops: 0, exp_fe: 1};
    vecs[5] = '{data: 8'h0F, stop: 1'b1, exp_pops: 1, exp_fe: 0};

    rst_n = 1'b0;
    rxd = 1'b1;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("reset out_valid", int'(out_valid), 0);
    check("reset out_data", int'(out_data), 0);
    check("reset busy", int'(busy), 0);
    check("reset framing_err", int'(framing_err), 0);
    check("reset overrun_err", int'(overrun_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);

    // table-driven single frames, consumer always ready
    for (int i = 0; i < 6; i++) begin
      p0 = pop_cnt; f0 = fe_cnt; o0 = ov_cnt; v0 = valid_hi_cnt;
      out_ready = 1'b1;
      send_frame(vecs[i].data, vecs[i].stop, -1);
      idle(20);
      check($sformatf("vec%0d pops", i), pop_cnt - p0, vecs[i].exp_pops);
      check($sformatf("vec%0d framing", i), fe_cnt - f0, vecs[i].exp_fe);
      check($sformatf("vec%0d overrun", i), ov_cnt - o0, 0);
      check($sformatf("vec%0d valid cycles", i), valid_hi_cnt - v0, vecs[i].exp_pops);
      if (vecs[i].exp_pops > 0) begin
        check($sformatf("vec%0d data", i), int'(last_pop), int'(vecs[i].data));
        check_range($sformatf("vec%0d latency", i), rise_edge - start_edge, 154, 156);
      end
    end

    // back-to-back frames with consumer stalled: second byte overruns
    out_ready = 1'b0;
    p0 = pop_cnt; o0 = ov_cnt; f0 = fe_cnt;
    send_frame(8'h3C, 1'b1, -1);
    send_frame(8'hC3, 1'b1, -1);
    idle(5);
    check("overrun out_valid held", int'(out_valid), 1);
    check("overrun out_data kept", int'(out_data), 'h3C);
    check("overrun pulse count", ov_cnt - o0, 1);
    check("overrun no framing", fe_cnt - f0, 0);
    check("overrun no pops", pop_cnt - p0, 0);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    #2;
    check("overrun drain valid drop", int'(out_valid), 0);
    check("overrun drain pops", pop_cnt - p0, 1);
    check("overrun drain data", int'(last_pop), 'h3C);
    out_ready = 1'b0;

    // start-bit glitch shorter than half a bit
    idle(5);
    b0 = busy_cnt; v0 = valid_hi_cnt; f0 = fe_cnt; o0 = ov_cnt;
    @(negedge clk);
    rxd = 1'b0;
    repeat (5) @(negedge clk);
    idle(20);
    check_range("glitch busy seen", busy_cnt - b0, 1, 20);
    check("glitch busy idle", int'(busy), 0);
    check("glitch no valid", valid_hi_cnt - v0, 0);
    check("glitch no framing", fe_cnt - f0, 0);
    check("glitch no overrun", ov_cnt - o0, 0);

    // bad stop bit followed by line held low: exactly one framing error
    out_ready = 1'b1;
    f0 = fe_cnt; v0 = valid_hi_cnt;
    send_frame(8'h55, 1'b0, -1);
    repeat (40) @(negedge clk);
    idle(20);
    check("break framing count", fe_cnt - f0, 1);
    check("break no valid", valid_hi_cnt - v0, 0);
    p0 = pop_cnt;
    send_frame(8'h0F, 1'b1, -1);
    idle(20);
    check("after break pops", pop_cnt - p0, 1);
    check("after break data", int'(last_pop), 'h0F);

    // simultaneous pop of 0x11 and push of 0x22
    out_ready = 1'b0;
    send_frame(8'h11, 1'b1, -1);
    idle(20);
    check("hold 0x11 valid", int'(out_valid), 1);
    check("hold 0x11 data", int'(out_data), 'h11);
    p0 = pop_cnt; o0 = ov_cnt; l0 = valid_lo_cnt;
    send_frame(8'h22, 1'b1, 154);
    idle(5);
    check("pushpop valid", int'(out_valid), 1);
    check("pushpop data", int'(out_data), 'h22);
    check("pushpop no overrun", ov_cnt - o0, 0);
    check("pushpop pops", pop_cnt - p0, 1);
    check("pushpop popped 0x11", int'(last_pop), 'h11);
    check("pushpop valid never low", valid_lo_cnt - l0, 0);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #2;
    check("pushpop drain data", int'(last_pop), 'h22);
    check("pushpop drain valid", int'(out_valid), 0);

    // reset in the middle of DATA with a byte held
    send_frame(8'h99, 1'b1, -1);
    idle(20);
    check("pre-reset held valid", int'(out_valid), 1);
    @(negedge clk);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    check("pre-reset busy", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset out_valid", int'(out_valid), 0);
    check("async reset out_data", int'(out_data), 0);
    check("async reset busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    out_ready = 1'b1;
    p0 = pop_cnt;
    send_frame(8'h81, 1'b1, -1);
    idle(20);
    check("post-reset pops", pop_cnt - p0, 1);
    check("post-reset data", int'(last_pop), 'h81);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
